// File: rtl/geared_rr_scheduler.sv
// geared_rr_scheduler: round-robin arbiter gated by gear phase, with fixed-latency response routing
module geared_rr_scheduler #(
  parameter int NumReq = 4,
  parameter int GearRatio = 2,
  parameter int RspLatency = 3,
  parameter type T = logic,
  parameter type RspT = logic
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic [GearRatio-1:0] slot_mask_i,
  input  logic [NumReq-1:0]    req_valid_i,
  output logic [NumReq-1:0]    req_ready_o,
  input  T                     req_data_i [NumReq],
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output T                     out_data_o,
  output logic [GearRatio-1:0] phase_o,
  input  logic                 rsp_valid_i,
  input  RspT                  rsp_data_i,
  output logic [NumReq-1:0]    rsp_valid_o,
  output RspT                  rsp_data_o,
  output logic                 err_o
);
  localparam int IdxW = NumReq > 1 ? $clog2(NumReq) : 1;

  logic [GearRatio-1:0]  phase, phase_nxt;
  logic [IdxW-1:0]       ptr, winner;
  logic                  en, hs;
  logic [RspLatency-1:0] line_v;
  logic [IdxW-1:0]       line_idx [RspLatency];

  generate
    if (GearRatio == 1) begin : g_one
      assign phase_nxt = phase;
    end else begin : g_ring
      assign phase_nxt = {phase[GearRatio-2:0], phase[GearRatio-1]};
    end
  endgenerate

  // Grants are suppressed while in reset or clear so no handshake escapes the line bookkeeping.
  assign en          = rst_ni & ~clr_i & |(phase & slot_mask_i);
  assign out_valid_o = en & |req_valid_i;
  assign hs          = out_valid_o & out_ready_i;
  assign out_data_o  = req_data_i[winner];
  assign req_ready_o = hs ? NumReq'(1) << winner : '0;
  assign phase_o     = phase;
  assign rsp_data_o  = rsp_data_i;
  assign rsp_valid_o = (rst_ni & line_v[RspLatency-1] & rsp_valid_i) ? NumReq'(1) << line_idx[RspLatency-1] : '0;
  assign err_o       = rst_ni & rsp_valid_i & ~line_v[RspLatency-1];

  // First valid requester at or after the pointer; scanning downward leaves the nearest one last.
  always_comb begin
    winner = ptr;
    for (int k = NumReq - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NumReq) j -= NumReq;
      if (req_valid_i[j]) winner = IdxW'(j);
    end
  end

  // Phase ring, fairness pointer and the response tag line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase  <= GearRatio'(1);
      ptr    <= '0;
      line_v <= '0;
      for (int k = 0; k < RspLatency; k++) line_idx[k] <= '0;
    end else if (clr_i) begin
      phase  <= GearRatio'(1);
      ptr    <= '0;
      line_v <= '0;
      for (int k = 0; k < RspLatency; k++) line_idx[k] <= '0;
    end else begin
      phase <= phase_nxt;
      if (hs) ptr <= (winner == IdxW'(NumReq - 1)) ? '0 : winner + 1'b1;
      for (int k = RspLatency - 1; k > 0; k--) begin
        line_v[k]   <= line_v[k-1];
        line_idx[k] <= line_idx[k-1];
      end
      line_v[0]   <= hs;
      line_idx[0] <= winner;
    end
  end
endmodule

// File: tb/tb_geared_rr_scheduler.sv
// tb_geared_rr_scheduler: directed checks of phase gating, round-robin grants and response routing
module tb_geared_rr_scheduler;
  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] mask = 2'b00;
  logic [3:0] req_valid = 4'h0;
  logic [3:0] req_ready;
  logic [7:0] req_data [4];
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [1:0] phase;
  logic       rsp_valid_in = 1'b0;
  logic [7:0] rsp_data_in = 8'h00;
  logic [3:0] rsp_valid;
  logic [7:0] rsp_data;
  logic       err;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  geared_rr_scheduler #(
    .NumReq(4), .GearRatio(2), .RspLatency(3), .T(logic [7:0]), .RspT(logic [7:0])
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr), .slot_mask_i(mask),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .phase_o(phase), .rsp_valid_i(rsp_valid_in), .rsp_data_i(rsp_data_in),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .err_o(err)
  );

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 1'b0; mask = 2'b11; req_valid = 4'h0; out_ready = 1'b1; rsp_valid_in = 1'b0; rsp_data_in = 8'h00;
  endtask

  // Leaves the bench 1 ns after a clock edge with reset just released (cycle 0, phase 01).
  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    nxt();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    logic [1:0] exp_ph [3];
    exp_ph = '{2'b01, 2'b10, 2'b01};
    idle();
    rst_ni = 1'b0; req_valid = 4'hF; rsp_valid_in = 1'b1;
    nxt(); #3;
    checks++;
    if ({phase, req_ready, out_valid, rsp_valid, err} !== {2'b01, 4'h0, 1'b0, 4'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_hold: got ph=%b rdy=%b ov=%b rv=%b err=%b expected ph=01 rdy=0000 ov=0 rv=0000 err=0", phase, req_ready, out_valid, rsp_valid, err);
    end
    nxt();
    rst_ni = 1'b1; req_valid = 4'h0; rsp_valid_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #3;
      checks++;
      if (phase !== exp_ph[c]) begin
        failures++;
        $display("FAIL reset_phase c%0d: got %b expected %b", c, phase, exp_ph[c]);
      end
      nxt();
    end
    req_valid = 4'hF;
    #3;
    checks++;
    if ({phase, out_valid, req_ready, out_data} !== {2'b10, 1'b1, 4'b0001, 8'h10}) begin
      failures++;
      $display("FAIL reset_pre_async: got ph=%b ov=%b rdy=%b data=%h expected ph=10 ov=1 rdy=0001 data=10", phase, out_valid, req_ready, out_data);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({phase, out_valid, req_ready} !== {2'b01, 1'b0, 4'h0}) begin
      failures++;
      $display("FAIL reset_async: got ph=%b ov=%b rdy=%b expected ph=01 ov=0 rdy=0000", phase, out_valid, req_ready);
    end
  endtask

  task automatic test_rr();
    logic [3:0] exp_rdy [5];
    logic [7:0] exp_dat [5];
    exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_dat = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    do_reset();
    req_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      #3;
      checks++;
      if ({req_ready, out_valid, out_data, err} !== {exp_rdy[c], 1'b1, exp_dat[c], 1'b0}) begin
        failures++;
        $display("FAIL rr c%0d: got rdy=%b ov=%b data=%h err=%b expected rdy=%b ov=1 data=%h err=0", c, req_ready, out_valid, out_data, err, exp_rdy[c], exp_dat[c]);
      end
      nxt();
    end
  endtask

  task automatic test_mask();
    logic [1:0] exp_ph [4];
    logic       exp_ov [4];
    logic [3:0] exp_rdy [4];
    exp_ph  = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_ov  = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_rdy = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
    do_reset();
    mask = 2'b01; req_valid = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      #3;
      checks++;
      if ({phase, out_valid, req_ready} !== {exp_ph[c], exp_ov[c], exp_rdy[c]}) begin
        failures++;
        $display("FAIL mask c%0d: got ph=%b ov=%b rdy=%b expected ph=%b ov=%b rdy=%b", c, phase, out_valid, req_ready, exp_ph[c], exp_ov[c], exp_rdy[c]);
      end
      nxt();
    end
  endtask

  task automatic test_stall();
    logic       rdy_in [5];
    logic [3:0] exp_rdy [5];
    logic [7:0] exp_dat [5];
    rdy_in  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_rdy = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0100};
    exp_dat = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h12};
    do_reset();
    req_valid = 4'b0110;
    for (int c = 0; c < 5; c++) begin
      out_ready = rdy_in[c];
      #3;
      checks++;
      if ({req_ready, out_valid, out_data} !== {exp_rdy[c], 1'b1, exp_dat[c]}) begin
        failures++;
        $display("FAIL stall c%0d: got rdy=%b ov=%b data=%h expected rdy=%b ov=1 data=%h", c, req_ready, out_valid, out_data, exp_rdy[c], exp_dat[c]);
      end
      nxt();
    end
  endtask

  task automatic test_routing();
    logic [3:0] vin [8];
    logic       rin [8];
    logic [3:0] exp_rv [8];
    logic       exp_err [8];
    vin     = '{4'b0100, 4'h0, 4'h0, 4'h0, 4'b0001, 4'h0, 4'h0, 4'h0};
    rin     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_rv  = '{4'h0, 4'h0, 4'h0, 4'b0100, 4'h0, 4'h0, 4'h0, 4'h0};
    exp_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req_valid = vin[c]; rsp_valid_in = rin[c]; rsp_data_in = 8'hA5 + 8'(c);
      #3;
      checks++;
      if ({rsp_valid, err} !== {exp_rv[c], exp_err[c]}) begin
        failures++;
        $display("FAIL route c%0d: got rv=%b err=%b expected rv=%b err=%b", c, rsp_valid, err, exp_rv[c], exp_err[c]);
      end
      if (c == 3) begin
        checks++;
        if (rsp_data !== 8'hA8) begin
          failures++;
          $display("FAIL route_data: got %h expected a8", rsp_data);
        end
      end
      if (c == 0 || c == 4) begin
        checks++;
        if (req_ready !== vin[c]) begin
          failures++;
          $display("FAIL route_grant c%0d: got %b expected %b", c, req_ready, vin[c]);
        end
      end
      nxt();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] vin [6];
    logic       rin [6];
    logic [3:0] exp_rdy [6];
    logic [3:0] exp_rv [6];
    vin     = '{4'b0011, 4'b0011, 4'h0, 4'h0, 4'h0, 4'h0};
    rin     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_rdy = '{4'b0001, 4'b0010, 4'h0, 4'h0, 4'h0, 4'h0};
    exp_rv  = '{4'h0, 4'h0, 4'h0, 4'b0001, 4'b0010, 4'h0};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      req_valid = vin[c]; rsp_valid_in = rin[c]; rsp_data_in = 8'h30 + 8'(c);
      #3;
      checks++;
      if ({req_ready, rsp_valid, err} !== {exp_rdy[c], exp_rv[c], 1'b0}) begin
        failures++;
        $display("FAIL b2b c%0d: got rdy=%b rv=%b err=%b expected rdy=%b rv=%b err=0", c, req_ready, rsp_valid, err, exp_rdy[c], exp_rv[c]);
      end
      nxt();
    end
  endtask

  task automatic test_errors();
    logic       cin [7];
    logic [3:0] vin [7];
    logic       rin [7];
    logic [3:0] exp_rdy [7];
    logic [1:0] exp_ph [7];
    logic       exp_err [7];
    cin     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vin     = '{4'h0, 4'h0, 4'h0, 4'b0010, 4'hF, 4'h0, 4'hF};
    rin     = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_rdy = '{4'h0, 4'h0, 4'h0, 4'b0010, 4'h0, 4'h0, 4'b0001};
    exp_ph  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
    exp_err = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      clr = cin[c]; req_valid = vin[c]; rsp_valid_in = rin[c];
      #3;
      checks++;
      if ({req_ready, phase, err, rsp_valid} !== {exp_rdy[c], exp_ph[c], exp_err[c], 4'h0}) begin
        failures++;
        $display("FAIL err c%0d: got rdy=%b ph=%b err=%b rv=%b expected rdy=%b ph=%b err=%b rv=0000", c, req_ready, phase, err, rsp_valid, exp_rdy[c], exp_ph[c], exp_err[c]);
      end
      nxt();
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) req_data[i] = 8'h10 + 8'(i);
    test_reset();
    test_rr();
    test_mask();
    test_stall();
    test_routing();
    test_back_to_back();
    test_errors();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
